// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_W         = 32;
  localparam int LINE_W         = 128;
  localparam int MEM_ADDR_W     = 28;
  localparam int PROC_ADDR_W    = 30;
  localparam int OFF_W          = $clog2(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;
endpackage

// File: rtl/dcache_if.sv
// Processor-side and memory-side buses of the data cache.
interface dcache_proc_if;
  import dcache_pkg::*;
  logic                   proc_read;
  logic                   proc_write;
  logic [PROC_ADDR_W-1:0] proc_addr;
  logic [WORD_W-1:0]      proc_wdata;
  logic [WORD_W-1:0]      proc_rdata;
  logic                   proc_stall;

  modport master (output proc_read, proc_write, proc_addr, proc_wdata,
                  input  proc_rdata, proc_stall);
  modport slave  (input  proc_read, proc_write, proc_addr, proc_wdata,
                  output proc_rdata, proc_stall);
endinterface

interface dcache_mem_if;
  import dcache_pkg::*;
  logic                  mem_read;
  logic                  mem_write;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]     mem_wdata;
  logic [LINE_W-1:0]     mem_rdata;
  logic                  mem_ready;

  modport master (output mem_read, mem_write, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_read, mem_write, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/dcache_line_array.sv
// Line storage: valid/dirty/tag/data per line, whole-line fill port and single-word store port.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [INDEX_W-1:0]            idx_i,
  input  logic                          fill_en_i,
  input  logic [MEM_ADDR_W-INDEX_W-1:0] fill_tag_i,
  input  logic [LINE_W-1:0]             fill_data_i,
  input  logic                          store_en_i,
  input  logic [OFF_W-1:0]              store_off_i,
  input  logic [WORD_W-1:0]             store_data_i,
  output logic                          valid_o,
  output logic                          dirty_o,
  output logic [MEM_ADDR_W-INDEX_W-1:0] tag_o,
  output logic [LINE_W-1:0]             line_o
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = MEM_ADDR_W - INDEX_W;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  // A fill always wins over a store; the FSM never requests both together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (fill_en_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
      tag_q[idx_i]   <= fill_tag_i;
      data_q[idx_i]  <= fill_data_i;
    end else if (store_en_i) begin
      dirty_q[idx_i] <= 1'b1;
      data_q[idx_i][{store_off_i, 5'd0} +: WORD_W] <= store_data_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];
endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped write-back/write-allocate data cache: same-cycle hits, stall on miss.
module dcache_direct
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  dcache_proc_if.slave  proc,
  dcache_mem_if.master  mem
);
  localparam int TAG_W = MEM_ADDR_W - INDEX_W;

  state_e             state_q, state_d;
  logic [OFF_W-1:0]   off;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic               line_valid, line_dirty;
  logic [TAG_W-1:0]   line_tag;
  logic [LINE_W-1:0]  line_data;
  logic               req, hit, fill_en, store_en;

  assign off     = proc.proc_addr[OFF_W-1:0];
  assign idx     = proc.proc_addr[INDEX_W+OFF_W-1:OFF_W];
  assign req_tag = proc.proc_addr[PROC_ADDR_W-1:INDEX_W+OFF_W];
  assign req     = proc.proc_read | proc.proc_write;
  assign hit     = line_valid && (line_tag == req_tag);

  dcache_line_array #(.INDEX_W(INDEX_W)) u_lines (
    .clk          (clk),
    .rst_n        (rst_n),
    .idx_i        (idx),
    .fill_en_i    (fill_en),
    .fill_tag_i   (req_tag),
    .fill_data_i  (mem.mem_rdata),
    .store_en_i   (store_en),
    .store_off_i  (off),
    .store_data_i (proc.proc_wdata),
    .valid_o      (line_valid),
    .dirty_o      (line_dirty),
    .tag_o        (line_tag),
    .line_o       (line_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Memory strobes depend on state only; a write with a read is handled as a write.
  always_comb begin
    state_d         = state_q;
    proc.proc_stall = 1'b0;
    mem.mem_read    = 1'b0;
    mem.mem_write   = 1'b0;
    mem.mem_addr    = {req_tag, idx};
    fill_en         = 1'b0;
    store_en        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            store_en = proc.proc_write;
          end else begin
            proc.proc_stall = 1'b1;
            state_d = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        proc.proc_stall = 1'b1;
        mem.mem_write   = 1'b1;
        mem.mem_addr    = {line_tag, idx};
        if (mem.mem_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        proc.proc_stall = 1'b1;
        mem.mem_read    = 1'b1;
        if (mem.mem_ready) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign proc.proc_rdata = line_data[{off, 5'd0} +: WORD_W];
  assign mem.mem_wdata   = line_data;
endmodule

// File: tb/tb_dcache_direct.sv
// Bench for dcache_direct: directed scenarios plus random traffic against a flat-memory reference.
module tb_dcache_direct;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcache_proc_if p ();
  dcache_mem_if  m ();

  dcache_direct #(.INDEX_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .proc  (p.slave),
    .mem   (m.master)
  );

  typedef struct {
    logic [29:0] addr;
    bit          wr;
    logic [31:0] data;
    bit          hit;
    int          wb;
  } txn_t;

  txn_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int          lat_fixed = -1;
  int          stall_cnt = 0;
  int          wb_cnt = 0;
  logic [31:0] backing [256];
  logic [31:0] ref_mem [256];
  bit          mv [8];
  bit          md [8];
  logic [2:0]  mt [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Reference: the cache is invisible except for timing, so reads must return the
  // last value written to that word; hit/writeback predicted from per-index tag state.
  task automatic issue(input logic [7:0] a, input bit wr, input logic [31:0] wd);
    txn_t e;
    int idx;
    idx    = int'(a[4:2]);
    e.addr = {22'd0, a};
    e.wr   = wr;
    e.hit  = mv[idx] && (mt[idx] == a[7:5]);
    e.wb   = (!e.hit && mv[idx] && md[idx]) ? 1 : 0;
    e.data = wr ? wd : ref_mem[a];
    if (!e.hit) begin
      mv[idx] = 1'b1;
      mt[idx] = a[7:5];
      md[idx] = 1'b0;
    end
    if (wr) begin
      md[idx]    = 1'b1;
      ref_mem[a] = wd;
    end
    sbq.push_back(e);
    p.proc_addr  = {22'd0, a};
    p.proc_wdata = wd;
    p.proc_write = wr;
    p.proc_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic wait_done(output int n);
    bit ok;
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (!p.proc_stall) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      failures++;
      $display("FAIL stall_timeout: actual=stalled expected=released within 100 cycles");
      finish_now();
    end
    @(posedge clk); #1;
    p.proc_read  = 1'b0;
    p.proc_write = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
      mt[i] = '0;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = backing[i];
  endtask

  // Memory responder: latency fixed or random, checks evicted lines against the reference.
  logic [7:0] rbase;
  int         lat;
  initial begin
    m.mem_ready = 1'b0;
    m.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      m.mem_ready = 1'b0;
      if (rst_n && (m.mem_read || m.mem_write)) begin
        lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
        repeat (lat) begin
          @(posedge clk); #1;
        end
        if (!rst_n || !(m.mem_read || m.mem_write)) continue;
        rbase = {m.mem_addr[5:0], 2'b00};
        if (m.mem_write) begin
          for (int w = 0; w < 4; w++) begin
            check("wb_line_word", m.mem_wdata[w*32 +: 32], ref_mem[rbase + 8'(w)]);
            backing[rbase + 8'(w)] = m.mem_wdata[w*32 +: 32];
          end
        end else begin
          m.mem_rdata = {backing[rbase + 8'd3], backing[rbase + 8'd2],
                         backing[rbase + 8'd1], backing[rbase]};
        end
        m.mem_ready = 1'b1;
      end
    end
  end

  // Monitor: each request is retired at the first sample where stall is low.
  txn_t e_mon;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sbq.delete();
        stall_cnt = 0;
        wb_cnt    = 0;
      end else if (p.proc_read || p.proc_write) begin
        if (p.proc_stall) begin
          stall_cnt++;
          if (m.mem_write && m.mem_ready) wb_cnt++;
        end else if (sbq.size() == 0) begin
          failures++;
          checks++;
          $display("FAIL sb_unexpected: actual=completion expected=no pending request");
        end else begin
          e_mon = sbq.pop_front();
          check("sb_addr", 128'(p.proc_addr), 128'(e_mon.addr));
          check("sb_hit", 128'(stall_cnt == 0), 128'(e_mon.hit));
          check("sb_writebacks", 128'(wb_cnt), 128'(e_mon.wb));
          if (!e_mon.wr) check("sb_rdata", 128'(p.proc_rdata), 128'(e_mon.data));
          stall_cnt = 0;
          wb_cnt    = 0;
        end
      end
    end
  end

  int n;
  int guard;
  initial begin
    rst_n        = 1'b0;
    p.proc_read  = 1'b0;
    p.proc_write = 1'b0;
    p.proc_addr  = '0;
    p.proc_wdata = '0;
    for (int i = 0; i < 256; i++) backing[i] = $urandom;
    for (int i = 0; i < 4; i++) backing[16 + i] = 32'hA5A5_0000 + 32'(i);
    model_reset();

    @(negedge clk);
    check("rst_stall", 128'(p.proc_stall), 128'(0));
    check("rst_mem_read", 128'(m.mem_read), 128'(0));
    check("rst_mem_write", 128'(m.mem_write), 128'(0));
    check("rst_rdata", 128'(p.proc_rdata), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Clean miss, k=2: stalls through t..t+3, released at t+4.
    lat_fixed = 2;
    issue(8'h10, 1'b0, 32'h0);
    @(negedge clk);
    check("miss_stall", 128'(p.proc_stall), 128'(1));
    @(negedge clk);
    check("alloc_read_addr", 128'({m.mem_read, m.mem_addr}), 128'({1'b1, 28'h0000004}));
    wait_done(n);
    check("clean_miss_latency", 128'(n), 128'(3));

    issue(8'h11, 1'b1, 32'hDEADBEEF);
    wait_done(n);
    check("store_hit_nostall", 128'(n), 128'(1));
    issue(8'h11, 1'b0, 32'h0);
    wait_done(n);
    check("load_hit_nostall", 128'(n), 128'(1));

    // Dirty miss to the same index, k=3 for both phases.
    lat_fixed = 3;
    issue(8'h31, 1'b0, 32'h0);
    @(negedge clk);
    check("dirty_miss_stall", 128'(p.proc_stall), 128'(1));
    @(negedge clk);
    check("wb_write_addr", 128'({m.mem_write, m.mem_read, m.mem_addr}), 128'({2'b10, 28'h0000004}));
    check("wb_word1", 128'(m.mem_wdata[63:32]), 128'(32'hDEADBEEF));
    guard = 0;
    while (!m.mem_read && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("wb_residency", 128'(guard), 128'(4));
    check("alloc_after_wb_addr", 128'({m.mem_write, m.mem_read, m.mem_addr}), 128'({2'b01, 28'h000000C}));
    wait_done(n);
    check("dirty_alloc_latency", 128'(n), 128'(4));

    // mem_ready held off for five ALLOCATE cycles.
    lat_fixed = 5;
    issue(8'h50, 1'b0, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("alloc_hold", 128'({m.mem_read, p.proc_stall, m.mem_ready, m.mem_addr}),
            128'({3'b110, 28'h0000014}));
    end
    @(negedge clk);
    check("alloc_6th_ready", 128'({m.mem_ready, p.proc_stall}), 128'(2'b11));
    wait_done(n);
    check("alloc_release", 128'(n), 128'(1));

    // Asynchronous reset in the middle of ALLOCATE.
    issue(8'h90, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("alloc_before_rst", 128'(m.mem_read), 128'(1));
    #2;
    rst_n        = 1'b0;
    p.proc_read  = 1'b0;
    p.proc_write = 1'b0;
    #1;
    check("rst_drops_mem_read", 128'({m.mem_read, m.mem_write, p.proc_stall}), 128'(0));
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    lat_fixed = 1;
    issue(8'h10, 1'b0, 32'h0);
    @(negedge clk);
    check("miss_after_reset", 128'(p.proc_stall), 128'(1));
    wait_done(n);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_quiet", 128'({p.proc_stall, m.mem_read, m.mem_write}), 128'(0));
    end

    // Random traffic over 8 tags x 8 indices with random memory latency.
    lat_fixed = -1;
    @(posedge clk); #1;
    for (int t = 0; t < 300; t++) begin
      issue(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $urandom);
      wait_done(n);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    repeat (3) @(negedge clk);
    check("sb_drained", 128'(sbq.size()), 128'(0));
    finish_now();
  end
endmodule

// File: doc/dcache_direct.md
# dcache_direct

Direct-mapped, write-back, write-allocate data cache that responds to the MEM pipeline stage's data-memory port. It accepts word-addressed read/write requests, answers hits in the same cycle, and holds the pipeline with `proc_stall` while it fetches or evicts 128-bit lines over a ready-handshaked memory bus. It sits between the MEM stage and the off-chip data memory model.

## Interface
- `INDEX_W`, default 3: index bits; line count = 2^INDEX_W (8 lines of 4 words). Tag width = 28 − INDEX_W.
- `clk` in 1: clock, all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `proc_read` in 1: load request from MEM stage.
- `proc_write` in 1: store request from MEM stage.
- `proc_addr` in 30: word address; [1:0] word offset, [INDEX_W+1:2] index, [29:INDEX_W+2] tag.
- `proc_wdata` in 32: store data, stored verbatim; byte ordering is handled upstream.
- `proc_rdata` out 32: word at index/offset of the indexed line.
- `proc_stall` out 1: request not yet serviced; pipeline freezes.
- `mem_read` out 1: line fetch request.
- `mem_write` out 1: line write-back request.
- `mem_addr` out 28: line address {tag, index}.
- `mem_wdata` out 128: evicted line, word 0 in [31:0].
- `mem_rdata` in 128: fetched line, word 0 in [31:0].
- `mem_ready` in 1: one-cycle pulse completing the pending memory request.

## Operation
- Per line: valid, dirty, tag, 4×32 data. Hit = valid & tag match on the indexed line.
- States: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no request: `proc_stall`=0, no memory traffic.
- IDLE, hit: `proc_stall`=0 combinationally; read returns word on `proc_rdata` in the same cycle; write updates the word and sets dirty at the edge.
- IDLE, miss: `proc_stall`=1 combinationally; next state WRITEBACK if line valid & dirty, else ALLOCATE.
- WRITEBACK: `mem_write`=1, `mem_addr`={stored tag, index}, `mem_wdata`=line; on `mem_ready` → ALLOCATE.
- ALLOCATE: `mem_read`=1, `mem_addr`={request tag, index}; on `mem_ready`, capture `mem_rdata` into the line, set valid, clear dirty, load tag → IDLE. The held request then hits in IDLE.
- `proc_stall`=1 in WRITEBACK and ALLOCATE.
- `proc_read` and `proc_write` both high: treated as a write.
- `mem_read`/`mem_write` decode from state only (Moore); never both high.
- `mem_addr` in IDLE = {request tag, index}; `mem_wdata` = indexed line in every state.

## Timing
- Reset (async, immediate): state IDLE; all valid/dirty/tag/data cleared; `mem_read`=`mem_write`=0; `proc_rdata`=0; `proc_stall`=0 with no request.
- Hit: zero-cycle latency, no stall.
- Clean miss, request at cycle t: t stall; t+1 ALLOCATE; `mem_ready` at t+1+k fills line; t+2+k IDLE hit, stall drops.
- Dirty miss: adds one WRITEBACK residency ending on its `mem_ready`.
- Processor holds `proc_addr`/`proc_read`/`proc_write`/`proc_wdata` stable while `proc_stall`=1. The cache holds `mem_*` stable until `mem_ready`.
- `mem_ready` outside WRITEBACK/ALLOCATE is ignored.
- Reset mid-WRITEBACK/ALLOCATE: memory requests drop in the same cycle; dirty data is discarded.

## Structure
- Shared package `dcache_pkg`: state enum (IDLE, WRITEBACK, ALLOCATE), `WORDS_PER_LINE`=4, `LINE_W`=128, `MEM_ADDR_W`=28.
- Sub-module `dcache_line_array`: valid/dirty/tag/data storage with async clear, a line write port (fill) and a word write port (store hit). The FSM and hit logic live in the top.

## Test plan
- Reset, read `proc_addr`=0x10 → stall; next cycle `mem_read`=1, `mem_addr`=0x0000004. `mem_ready` with `mem_rdata`={W3,W2,W1,W0} → next cycle stall=0, `proc_rdata`=W0.
- After that fill, write 0x11 with 0xDEADBEEF → no stall. Read 0x11 → 0xDEADBEEF, no stall.
- Read 0x31 (same index, tag 1) → WRITEBACK: `mem_addr`=0x0000004, `mem_wdata`[63:32]=0xDEADBEEF. Then ALLOCATE: `mem_addr`=0x000000C.
- Hold `mem_ready` low for 5 cycles in ALLOCATE → `mem_read` and `proc_stall` stay 1, `mem_addr` stable. Fill completes on the 6th cycle.
- Assert `rst_n`=0 during ALLOCATE → `mem_read` drops without a clock edge. Re-request 0x10 → miss again.
- No request for 10 cycles → `proc_stall`=0, `mem_read`=`mem_write`=0 throughout.
